// File: rtl/mm_host_sequencer.sv
// Host-side job sequencer for the 4x4 matmul chip top: streams 32 operand bytes in,
// drives write/load/matmul/read strobes, and streams the 16 result bytes out.
module mm_host_sequencer #(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned HOLD_CYC  = 2,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy,
  output logic       error,
  output logic       mm_en,
  output logic [6:0] mm_aux,
  output logic [7:0] mm_data_in,
  input  logic [7:0] mm_data_out,
  input  logic       mm_interrupt
);

  typedef enum logic [3:0] {
    S_IDLE, S_W_FETCH, S_W_SETUP, S_W_STROBE,
    S_L_SETUP, S_L_WAIT, S_M_SETUP, S_M_WAIT,
    S_R_SETUP, S_R_STROBE, S_R_PUSH, S_ERROR
  } state_t;

  typedef enum logic [1:0] {
    MODE_MATMUL = 2'b00,
    MODE_WRITE  = 2'b01,
    MODE_LOAD   = 2'b10,
    MODE_READ   = 2'b11
  } mode_t;

  localparam int unsigned PH_MAX = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int unsigned PW     = $clog2(PH_MAX + 1);
  localparam int unsigned TW     = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] SETUP_LAST = PW'(SETUP_CYC - 1);
  localparam logic [PW-1:0] HOLD_LAST  = PW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [TW-1:0] wait_q, wait_d;
  logic          mm_en_q, mm_en_d;
  logic [6:0]    aux_q, aux_d;
  logic [7:0]    din_q, din_d;
  logic [7:0]    dout_q, dout_d;
  logic          err_q, err_d;
  logic [4:0]    fetch_cnt;

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ph_q    <= '0;
      wait_q  <= '0;
      mm_en_q <= 1'b0;
      aux_q   <= '0;
      din_q   <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      wait_q  <= wait_d;
      mm_en_q <= mm_en_d;
      aux_q   <= aux_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  assign in_ready   = ((state_q == S_IDLE) || (state_q == S_W_FETCH)) && !clear;
  assign out_valid  = (state_q == S_R_PUSH);
  assign busy       = (state_q != S_IDLE);
  assign error      = err_q;
  assign mm_en      = mm_en_q;
  assign mm_aux     = aux_q;
  assign mm_data_in = din_q;
  assign out_data   = dout_q;
  assign fetch_cnt  = (state_q == S_IDLE) ? 5'd0 : cnt_q;

  // en/aux/data are all registered from the next-state decision, so aux and data
  // only ever move on the edge that enters a SETUP state (en low).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    wait_d  = wait_q;
    mm_en_d = mm_en_q;
    aux_d   = aux_q;
    din_d   = din_q;
    dout_d  = dout_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE, S_W_FETCH: begin
        if (in_valid) begin
          state_d = S_W_SETUP;
          cnt_d   = fetch_cnt;
          din_d   = in_data;
          aux_d   = {fetch_cnt, MODE_WRITE};
          ph_d    = '0;
        end
      end
      S_W_SETUP, S_R_SETUP: begin
        if (ph_q == SETUP_LAST) begin
          state_d = (state_q == S_W_SETUP) ? S_W_STROBE : S_R_STROBE;
          ph_d    = '0;
          mm_en_d = 1'b1;
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      S_W_STROBE: begin
        if (ph_q == HOLD_LAST) begin
          ph_d    = '0;
          mm_en_d = 1'b0;
          if (cnt_q == 5'd31) begin
            state_d = S_L_SETUP;
            cnt_d   = '0;
            aux_d   = {5'd0, MODE_LOAD};
          end else begin
            state_d = S_W_FETCH;
            cnt_d   = cnt_q + 5'd1;
          end
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      // Setup saturates at its minimum length; a stale interrupt keeps en low.
      S_L_SETUP, S_M_SETUP: begin
        if (ph_q != SETUP_LAST) begin
          ph_d = ph_q + PW'(1);
        end else if (!mm_interrupt) begin
          state_d = (state_q == S_L_SETUP) ? S_L_WAIT : S_M_WAIT;
          ph_d    = '0;
          wait_d  = '0;
          mm_en_d = 1'b1;
        end
      end
      S_L_WAIT, S_M_WAIT: begin
        if (mm_interrupt) begin
          mm_en_d = 1'b0;
          ph_d    = '0;
          if (state_q == S_L_WAIT) begin
            state_d = S_M_SETUP;
            aux_d   = {5'd0, MODE_MATMUL};
          end else begin
            state_d = S_R_SETUP;
            cnt_d   = '0;
            aux_d   = {5'd0, MODE_READ};
          end
        end else if (wait_q == TO_LAST) begin
          state_d = S_ERROR;
          mm_en_d = 1'b0;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end
      S_R_STROBE: begin
        if (ph_q == HOLD_LAST) begin
          state_d = S_R_PUSH;
          ph_d    = '0;
          mm_en_d = 1'b0;
          dout_d  = mm_data_out;
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      S_R_PUSH: begin
        if (out_ready) begin
          if (cnt_q == 5'd15) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_R_SETUP;
            cnt_d   = cnt_q + 5'd1;
            aux_d   = {1'b0, cnt_q[3:0] + 4'd1, MODE_READ};
          end
        end
      end
      S_ERROR: begin
        mm_en_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/mm_host_sequencer.md
# mm_host_sequencer

Upstream host-side sequencer for the 4x4 matrix-multiply chip top. It accepts a byte stream of operands on a valid/ready interface and drives the chip top's strobe protocol: `en` strobes, 7-bit `AUX` select bus, 8-bit data bus, and `interrupt` wait. In order it performs the 32-byte operand write, the register-file load, and the matmul. It then reads the 16 result bytes back and emits them on a valid/ready output stream. It replaces hand-sequenced host stimulus, so one module owns the entire job protocol.

## Interface
Parameters:
- SETUP_CYC, 2, cycles `mm_en` is held low with address/data stable before each strobe (≥1)
- HOLD_CYC, 2, cycles `mm_en` is held high per element strobe (≥1)
- TIMEOUT, 255, maximum cycles waiting for `mm_interrupt` in a wait state before error

Ports:
- clk  in  1  single clock, all logic on rising edge
- clear  in  1  reset, synchronous, active-high
- in_valid  in  1  operand byte valid
- in_ready  out  1  operand byte accepted when high with in_valid
- in_data  in  8  operand byte; order: reg 0..7, idx 0..3 within reg (regs 0-3 inputs, 4-7 transposed weights)
- out_valid  out  1  result byte valid
- out_ready  in  1  downstream accepts result
- out_data  out  8  result byte; order: reg 0..3, idx 0..3
- busy  out  1  high whenever state ≠ IDLE
- error  out  1  sticky interrupt timeout flag
- mm_en  out  1  chip-top enable/strobe
- mm_aux  out  7  {reg_select[2:0], idx_select[1:0], load, write}
- mm_data_in  out  8  byte to chip top
- mm_data_out  in  8  byte from chip top
- mm_interrupt  in  1  chip-top completion flag

## Operation
- Mode encodings on {load,write}: WRITE=01, LOAD=10, MATMUL=00, READ=11.
- Element counter `cnt` (5 bits). In the write phase: reg=cnt[4:2], idx=cnt[1:0]. In the read phase: reg={0,cnt[3:2]}, idx=cnt[1:0].
- States:
  - IDLE: in_ready=1. On handshake, latch in_data into mm_data_in, cnt=0, go to W_SETUP.
  - W_FETCH: same as IDLE for cnt>0. Gaps in in_valid stall here with mm_en=0.
  - W_SETUP: mm_en=0, aux={reg,idx,WRITE}. After SETUP_CYC cycles, go to W_STROBE.
  - W_STROBE: mm_en=1 for HOLD_CYC cycles. Then, if cnt==31, go to L_SETUP with cnt=0; else cnt++ and go to W_FETCH.
  - L_SETUP / M_SETUP: mm_en=0, aux mode LOAD / MATMUL, reg/idx=0. Exit only after ≥SETUP_CYC cycles and mm_interrupt==0.
  - L_WAIT / M_WAIT: mm_en=1 until mm_interrupt==1. L_WAIT then goes to M_SETUP; M_WAIT goes to R_SETUP.
  - R_SETUP: mm_en=0, aux={reg,idx,READ}, for SETUP_CYC cycles.
  - R_STROBE: mm_en=1 for HOLD_CYC cycles. Capture mm_data_out into out_data on the last strobe cycle, then go to R_PUSH.
  - R_PUSH: mm_en=0, out_valid=1, out_data stable until out_ready. On the handshake, if cnt==15 go to IDLE; else cnt++ and go to R_SETUP.
  - ERROR: mm_en=0, error=1, in_ready=0, out_valid=0. Held until clear.
- Timeout: a wait counter resets on entering L_WAIT/M_WAIT. If it reaches TIMEOUT without mm_interrupt, go to ERROR.
- No arithmetic on data. Bytes pass through unmodified, 8-bit.

## Timing
- Reset (clear high at a clock edge) forces state=IDLE, cnt=0, and all counters 0. Outputs: mm_en=0, mm_aux=0, mm_data_in=0, out_data=0, out_valid=0, error=0, busy=0. in_ready is forced 0 while clear is high.
- clear mid-job aborts immediately with no completion of the current strobe. The next cycle is IDLE.
- All chip-facing outputs are registered and change only while mm_en=0, i.e. on SETUP entry. aux/data are stable for the full SETUP+HOLD window.
- Per-byte write cost: 1 fetch cycle + SETUP_CYC + HOLD_CYC. With defaults and no input gaps this is 160 cycles for 32 bytes.
- A result byte presents out_valid 1 cycle after its strobe ends.
- A stale mm_interrupt still high from LOAD blocks the M_SETUP exit. en never rises while interrupt is high.
- The interrupt is sampled in WAIT only: mm_interrupt high in the first WAIT cycle exits on the next edge.

## Test plan
- Behavioral chip-top stub (matmul of regs 0-3 by regs 4-7), all 32 operands = {1,2,3,4} per reg, out_ready=1 → 16 out bytes, each 30 (0x1E). aux sequence WRITE×32, LOAD, MATMUL, READ×16; error=0; busy falls after the last handshake.
- Operands A rows {0,2,3,1},{0,2,0,3},{1,2,4,4},{0,2,4,2}, Wt rows {2,2,0,0},{2,4,4,0},{4,1,4,1},{2,4,1,4} → first out row 4,20,15,15.
- in_valid deasserted for 10 cycles after byte 5 → mm_en stays 0 during the gap; no extra strobes; totals still 32 WRITE strobes.
- out_ready held 0 for 20 cycles on result byte 3 → out_valid/out_data stable throughout, no further mm_en strobe, correct order resumes.
- Stub never raises interrupt in M_WAIT → error=1 after TIMEOUT cycles, mm_en=0, out_valid never asserts; clear returns to IDLE with error=0.
- Stub holds interrupt high 4 cycles after LOAD completes → M_SETUP lasts ≥4 cycles. Separately, clear asserted in R_STROBE of byte 7 → next cycle all outputs at reset values and in_ready=1.
